comparator_seq_accum: RTL and testbench

COMPARATOR_SEQ_ACCUM -- requirements
Module: comparator_seq_accum

---
 rtl/comparator_seq_accum.sv | 131 +++++++++++++
 tb/tb_comparator_seq_accum.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/comparator_seq_accum.sv
// comparator_seq_accum
// Folds a stream of 2-bit slice compare results (MSB slice first) into one
// word-level lt/gt/eq result. The first non-equal well-formed slice decides
// the word. Any malformed slice triplet poisons the word through err.
module comparator_seq_accum #(
    parameter int NSLICE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic slice_valid,
    input  logic l_in,
    input  logic g_in,
    input  logic e_in,
    output logic slice_ready,
    output logic busy,
    output logic done,
    output logic lt,
    output logic gt,
    output logic eq,
    output logic err
);

    localparam int CW = (NSLICE > 2) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          decided_q, decided_d;
    logic          pend_lt_q, pend_lt_d;   // 1: pending lt, 0: pending gt
    logic          err_q, err_d;
    logic          slice_ready_q, busy_q, done_q;
    logic          lt_q, gt_q, eq_q;

    logic          accept;
    logic          wellformed;
    logic          launch;

    // Slice acceptance, well-formedness and next pending-result state
    always_comb begin
        accept     = slice_valid && slice_ready_q;
        // exactly one of l/g/e set
        wellformed = (l_in ^ g_in ^ e_in) & ~(l_in & g_in & e_in);
        launch     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        decided_d  = decided_q;
        pend_lt_d  = pend_lt_q;
        err_d      = err_q;
        if (accept) begin
            if (!wellformed) begin
                err_d = 1'b1;
            end else if (!decided_q && (l_in || g_in)) begin
                decided_d = 1'b1;
                pend_lt_d = l_in;
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            decided_q     <= 1'b0;
            pend_lt_q     <= 1'b0;
            err_q         <= 1'b0;
            slice_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lt_q          <= 1'b0;
            gt_q          <= 1'b0;
            eq_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                // Shared by IDLE and DONE so back-to-back words need no idle cycle
                state_q       <= S_RUN;
                cnt_q         <= '0;
                decided_q     <= 1'b0;
                err_q         <= 1'b0;
                slice_ready_q <= 1'b1;
                busy_q        <= 1'b1;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (accept) begin
                            decided_q <= decided_d;
                            pend_lt_q <= pend_lt_d;
                            err_q     <= err_d;
                            if (cnt_q == LAST) begin
                                state_q       <= S_DONE;
                                slice_ready_q <= 1'b0;
                                busy_q        <= 1'b0;
                                done_q        <= 1'b1;
                                if (err_d) begin
                                    {lt_q, gt_q, eq_q} <= 3'b000;
                                end else if (!decided_d) begin
                                    {lt_q, gt_q, eq_q} <= 3'b001;
                                end else begin
                                    {lt_q, gt_q, eq_q} <= {pend_lt_d, ~pend_lt_d, 1'b0};
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign slice_ready = slice_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign lt          = lt_q;
    assign gt          = gt_q;
    assign eq          = eq_q;
    assign err         = err_q;

endmodule

// File: tb/tb_comparator_seq_accum.sv
// Directed bench for comparator_seq_accum (NSLICE = 4).
module tb_comparator_seq_accum;

    logic clk = 1'b0;
    logic rst, start, slice_valid, l_in, g_in, e_in;
    logic slice_ready, busy, done, lt, gt, eq, err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    comparator_seq_accum #(.NSLICE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .slice_valid (slice_valid),
        .l_in        (l_in),
        .g_in        (g_in),
        .e_in        (e_in),
        .slice_ready (slice_ready),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle before driving/sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one slice {l,g,e} for a single cycle
    task automatic slice(input logic [2:0] lge);
        slice_valid = 1'b1;
        {l_in, g_in, e_in} = lge;
        tick();
        slice_valid = 1'b0;
        {l_in, g_in, e_in} = 3'b000;
    endtask

    localparam logic [2:0] SL = 3'b100;
    localparam logic [2:0] SG = 3'b010;
    localparam logic [2:0] SE = 3'b001;
    localparam logic [2:0] SBAD = 3'b110;

    initial begin
        rst = 1'b1; start = 1'b1; slice_valid = 1'b0;
        l_in = 1'b0; g_in = 1'b0; e_in = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {1'b0, slice_ready, busy, done, lt, gt, eq, err}, 8'h00);
        rst = 1'b0; start = 1'b0;

        // idle ignores slices
        slice(SL);
        chk("idle_ignore", {5'b0, slice_ready, busy, done}, 8'h00);

        // Word 1: a=0xB4 b=0xB7 -> e,e,e,l
        start = 1'b1; tick(); start = 1'b0;
        chk("w1_run", {5'b0, slice_ready, busy, done}, 8'h06);
        slice(SE); slice(SE); slice(SE);
        chk("w1_nodone_before_last", {7'b0, done}, 8'h00);
        slice(SL);
        chk("w1_done", {5'b0, slice_ready, busy, done}, 8'h01);
        chk("w1_result", {4'b0, lt, gt, eq, err}, 8'h08);
        tick();
        chk("w1_idle", {5'b0, slice_ready, busy, done}, 8'h00);
        chk("w1_hold", {4'b0, lt, gt, eq, err}, 8'h08);

        // Word 2: a=0xC0 b=0x3F -> g,l,l,l ; start raised mid-run is ignored
        start = 1'b1; tick(); start = 1'b0;
        chk("w2_prev_held_in_run", {4'b0, lt, gt, eq, err}, 8'h08);
        slice(SG);
        start = 1'b1;
        slice(SL);
        start = 1'b0;
        slice(SL);
        chk("w2_still_running", {5'b0, slice_ready, busy, done}, 8'h06);
        slice(SL);
        chk("w2_done", {7'b0, done}, 8'h01);
        chk("w2_result", {4'b0, lt, gt, eq, err}, 8'h04);
        tick();

        // Word 3: a=b=0x5A, two idle cycles between slices
        start = 1'b1; tick(); start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            slice(SE);
            if (done) n_done++;
            if (i < 3) begin
                for (int k = 0; k < 2; k++) begin
                    chk("w3_busy_gap", {6'b0, busy, done}, 8'h02);
                    tick();
                    if (done) n_done++;
                end
            end
        end
        chk("w3_result", {4'b0, lt, gt, eq, err}, 8'h02);
        tick();
        if (done) n_done++;
        tick();
        if (done) n_done++;
        chk("w3_done_count", 8'(n_done), 8'd1);

        // Word 4: slice 1 malformed (l=g=1)
        start = 1'b1; tick(); start = 1'b0;
        slice(SE);
        chk("w4_err_clear", {7'b0, err}, 8'h00);
        slice(SBAD);
        chk("w4_err_sticky", {7'b0, err}, 8'h01);
        slice(SL); slice(SE);
        chk("w4_done", {7'b0, done}, 8'h01);
        chk("w4_result", {4'b0, lt, gt, eq, err}, 8'h01);
        tick();
        chk("w4_err_held_idle", {7'b0, err}, 8'h01);
        start = 1'b1; tick(); start = 1'b0;
        chk("w5_err_cleared", {6'b0, busy, err}, 8'h02);

        // Word 5: start held through DONE -> immediate next word
        start = 1'b1;
        slice(SG); slice(SE); slice(SL); slice(SE);
        chk("w5_done", {5'b0, slice_ready, busy, done}, 8'h01);
        chk("w5_result", {4'b0, lt, gt, eq, err}, 8'h04);
        tick();
        chk("w6_b2b_run", {5'b0, slice_ready, busy, done}, 8'h06);
        start = 1'b0;
        slice(SE); slice(SL); slice(SE);

        // rst after slice 2 wins over start and slice_valid
        rst = 1'b1; start = 1'b1; slice_valid = 1'b1; l_in = 1'b1;
        tick();
        chk("rst_mid_word", {1'b0, slice_ready, busy, done, lt, gt, eq, err}, 8'h00);
        rst = 1'b0; start = 1'b0; slice_valid = 1'b0; l_in = 1'b0;
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        chk("rst_no_done", 8'(n_done), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
